// File: rtl/cyber_press_gen.sv
// Computer opponent for the tug-of-war game: prescaled LFSR vs difficulty yields 1-cycle press pulses.
// Optional feature: define CYBER_SEED_EN to add seed_load/seed ports for reseeding the LFSR.
module cyber_press_gen #(
    parameter int unsigned LFSR_W   = 10,
    parameter int unsigned DIV      = 1024,
    parameter int unsigned COOLDOWN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [LFSR_W-1:0] difficulty,
    input  logic              game_over,
`ifdef CYBER_SEED_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
`endif
    output logic              press,
    output logic [LFSR_W-1:0] lfsr_q
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [LFSR_W-1:0] lfsr_d;
    logic [CW-1:0]     cool_cnt_q, cool_cnt_d;
    logic              press_q, press_d;
    logic              tick;
    logic              win;
    logic              fb;

    always_comb begin
        tick    = enable && (presc_q == PW'(DIV - 1));
        presc_d = presc_q;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        fb     = ~(lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-4]);
        lfsr_d = lfsr_q;
        if (tick) begin
            lfsr_d = (&lfsr_q) ? '0 : {lfsr_q[LFSR_W-2:0], fb};
        end
`ifdef CYBER_SEED_EN
        if (seed_load) begin
            lfsr_d  = (&seed) ? '0 : seed;
            presc_d = '0;
        end
`endif
        // compare uses the pre-shift LFSR value of the tick cycle
        win = (difficulty > lfsr_q);
    end

    always_comb begin
        state_d    = state_q;
        cool_cnt_d = cool_cnt_q;
        case (state_q)
            IDLE: begin
                cool_cnt_d = '0;
                if (tick && win) state_d = PRESS;
            end
            PRESS: begin
                state_d    = COOL;
                cool_cnt_d = CW'(COOLDOWN);
            end
            COOL: begin
                if (tick) begin
                    if (cool_cnt_q == CW'(1)) begin
                        state_d    = IDLE;
                        cool_cnt_d = '0;
                    end else begin
                        cool_cnt_d = cool_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                cool_cnt_d = '0;
            end
        endcase
        if (game_over) begin
            state_d    = IDLE;
            cool_cnt_d = '0;
        end
        press_d = (state_d == PRESS);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            lfsr_q     <= '0;
            cool_cnt_q <= '0;
            press_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            lfsr_q     <= lfsr_d;
            cool_cnt_q <= cool_cnt_d;
            press_q    <= press_d;
        end
    end

    assign press = press_q;

endmodule
